// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between the bridge (master) and the memory responder (slave).
interface apb_slave_mem_if #(
  parameter int WIDTH  = 32,
  parameter int SLAVES = 4
) ();
  logic [SLAVES-1:0] Pselx;
  logic              Penable;
  logic              Pwrite;
  logic [WIDTH-1:0]  Paddr;
  logic [WIDTH-1:0]  Pwdata;
  logic [WIDTH-1:0]  Prdata;

  modport master (output Pselx, Penable, Pwrite, Paddr, Pwdata, input Prdata);
  modport slave  (input Pselx, Penable, Pwrite, Paddr, Pwdata, output Prdata);
endinterface

// File: rtl/apb_slave_mem.sv
// APB responder: zero-wait-state word memory, phase-sequence checker and
// completed-transfer counters. Tracks the phase seen in the previous cycle.
module apb_slave_mem #(
  parameter int WIDTH     = 32,
  parameter int SLAVES    = 4,
  parameter int SLAVE_IDX = 0,
  parameter int AW        = 4
) (
  input  logic                  Hclk,
  input  logic                  Hreset,
  apb_slave_mem_if.slave        apb,
  output logic                  prot_err,
  output logic [7:0]            wr_count,
  output logic [7:0]            rd_count
);
  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} st_e;

  st_e              st_q;
  logic [AW-1:0]    a_idx_q;
  logic             a_wr_q;
  logic [WIDTH-1:0] prdata_q;
  logic             err_q;
  logic [7:0]       wr_cnt_q;
  logic [7:0]       rd_cnt_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic          sel;
  logic [AW-1:0] idx;
  logic          unused_bits;

  assign sel = apb.Pselx[SLAVE_IDX];
  // Byte offset and upper address bits are ignored, so the memory aliases.
  assign idx = apb.Paddr[AW+1:2];
  assign unused_bits = ^{apb.Pselx, apb.Paddr[WIDTH-1:AW+2], apb.Paddr[1:0]};

  assign apb.Prdata = prdata_q;
  assign prot_err   = err_q;
  assign wr_count   = wr_cnt_q;
  assign rd_count   = rd_cnt_q;

  // Phase tracker, memory, read-data register, error flag and counters.
  // Read data is fetched on the setup edge so it is valid for the whole
  // access phase; writes commit on the edge that ends the access phase.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      st_q     <= IDLE;
      a_idx_q  <= '0;
      a_wr_q   <= 1'b0;
      prdata_q <= '0;
      err_q    <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (!sel) begin
      // Deselect: a setup not followed by an access is abandoned.
      st_q <= IDLE;
      if (st_q == SETUP) err_q <= 1'b1;
    end else if (!apb.Penable) begin
      // Setup phase; a repeated setup is flagged but still taken as fresh.
      if (st_q == SETUP) err_q <= 1'b1;
      st_q    <= SETUP;
      a_idx_q <= idx;
      a_wr_q  <= apb.Pwrite;
      if (!apb.Pwrite) prdata_q <= mem_q[idx];
    end else if (st_q == SETUP && idx == a_idx_q && apb.Pwrite == a_wr_q) begin
      // Legal access phase: commit and count.
      st_q <= ACCESS;
      if (a_wr_q) begin
        mem_q[a_idx_q] <= apb.Pwdata;
        wr_cnt_q       <= wr_cnt_q + 8'd1;
      end else begin
        rd_cnt_q <= rd_cnt_q + 8'd1;
      end
    end else begin
      // Access without matching setup, or Penable held: drop it.
      err_q <= 1'b1;
      st_q  <= IDLE;
    end
  end
endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB responder at the far end of the AHB-to-APB bridge. It decodes one `Pselx` line, runs a SETUP/ACCESS tracking state machine, and serves a word-addressed register memory with zero-wait-state APB transfers. It also checks the incoming APB phase sequence and counts completed transfers. It sits behind the bridge's APB master outputs (`Pselx`, `Penable`, `Pwrite`, `Paddr`, `Pwdata`) and drives `Prdata` back to it.

## Interface
Parameters:
- `WIDTH`, 32: data and address width; matches the design-wide `WIDTH`.
- `SLAVES`, 4: width of the `Pselx` bus.
- `SLAVE_IDX`, 0: the `Pselx` bit this instance responds to.
- `AW`, 4: memory index width; `DEPTH = 2**AW` words.

Ports (one clock; reset is synchronous and active-high):
- `Hclk`  in  1  clock for all state; every register updates on the rising edge.
- `Hreset`  in  1  synchronous active-high reset.
- `Pselx`  in  SLAVES  slave selects; only bit `SLAVE_IDX` (`sel`) is used.
- `Penable`  in  1  APB access-phase strobe.
- `Pwrite`  in  1  1 = write, 0 = read.
- `Paddr`  in  WIDTH  byte address.
- `Pwdata`  in  WIDTH  write data.
- `Prdata`  out  WIDTH  read data, registered.
- `prot_err`  out  1  sticky protocol-violation flag.
- `wr_count`  out  8  completed writes, wraps 255 -> 0.
- `rd_count`  out  8  completed reads, wraps 255 -> 0.

## Operation
- Word index `idx = Paddr[AW+1:2]`. `Paddr[1:0]` and bits above `AW+1` are ignored, so the memory aliases every `DEPTH*4` bytes.
- State register `st` records the phase seen in the previous cycle: `IDLE`, `SETUP` or `ACCESS`. Latched registers: `a_idx`, `a_wr`.
- Transitions are evaluated at each edge from `st` and the current inputs:
  - `sel=0`: `st` goes to `IDLE`. If `st=SETUP`, this is an abandoned setup: set `prot_err`.
  - `sel=1, Penable=0` from `IDLE` or `ACCESS`: `st` goes to `SETUP`. Latch `a_idx<=idx` and `a_wr<=Pwrite`. On a read (`Pwrite=0`), also load `Prdata<=mem[idx]`.
  - `sel=1, Penable=0` while `st=SETUP` (setup repeated): set `prot_err` and treat it as a fresh setup (re-latch; a read reloads `Prdata`).
  - `sel=1, Penable=1` with `st=SETUP`, `idx==a_idx` and `Pwrite==a_wr`: this is the access. `st` goes to `ACCESS`. A write does `mem[a_idx]<=Pwdata` and `wr_count+1`; a read does `rd_count+1`.
  - `sel=1, Penable=1` with `st=SETUP` but `idx` or `Pwrite` changed: set `prot_err`, no commit, no count, `st` goes to `IDLE`.
  - `sel=1, Penable=1` with `st=IDLE` or `ACCESS` (access without setup, or `Penable` held): set `prot_err`, no commit, `st` goes to `IDLE`.
- `Prdata` changes only on a read-setup edge or on reset; otherwise it holds its last value.
- `prot_err` is cleared only by reset.
- Back-to-back transfers are supported: ACCESS then SETUP on consecutive cycles with no idle between.

## Timing
- Reset values: `Prdata=0`, `prot_err=0`, `wr_count=0`, `rd_count=0`, `st=IDLE`, `a_idx=0`, `a_wr=0`, all memory words 0.
- Reset dominates every other event in the same cycle.
- A reset during SETUP or ACCESS discards the transfer: no write commit, no count.
- Read latency: `Prdata` is valid from the first cycle of the access phase, one edge after the setup phase. It is stable for the whole of `Penable=1`.
- Write latency: memory updates at the edge ending the access phase. A read whose setup starts in the following cycle returns the new value.
- Minimum transfer length is 2 cycles with zero wait states. No `PREADY` or `PSLVERR` is generated.
- Counter wrap: 255 + 1 gives 0, with no flag.

## Test plan
- Apply reset, then read index 5 -> `Prdata=0x00000000` during access, `rd_count=1`, `prot_err=0`.
- Write `0xDEADBEEF` to `Paddr=0x14`, then immediately read `0x14` (back-to-back, no idle) -> `Prdata=0xDEADBEEF` in the read access cycle, `wr_count=1`, `rd_count=1`.
- Write `0x11` to `Paddr=0x04`, then read `Paddr=0x44` (alias, `AW=4`) -> `Prdata=0x11`. Drive `Pselx` with only a different bit set during a write -> memory unchanged, counts unchanged.
- Protocol errors, with a reset between each case:
  - `Penable=1` with no setup -> `prot_err=1`.
  - `Paddr` changes from `0x08` to `0x0C` between setup and access -> no write, `wr_count` unchanged.
  - `Penable` held for 2 cycles -> `prot_err=1`, `wr_count` incremented exactly once.
- Assert `Hreset` in the access cycle of a write of `0xA5A5A5A5` to `0x00` -> after release, a read of `0x00` returns 0 and `wr_count=0`.
- Perform 256 writes -> `wr_count` wraps to 0. Then 1 read -> `rd_count=1`.
